line_mem_adapter: RTL and testbench
===================================

# line_mem_adapter

Memory-side adapter directly downstream of the L1 cache controller's memory request port. Accepts one 128-bit cache-line request (write-back or refill) from the cache controller and performs it as a four-beat burst of 32-bit word transfers on a req/ack word bus toward L2/main memory. For refills it assembles the returned words into a line. It reports completion with a single-cycle `ready` pulse, which the cache controller's WRITE_BACK and ALLOCATE states wait on.

## Interface
Parameters:
- `BASE_LANE`, default 0: lane index of the first beat. Beats go lane BASE_LANE, BASE_LANE+1, … modulo 4. Legal values 0..3.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; one clock; reset is asynchronous and active-high.
- `mem_req_i`  in  `mem_req_type`  request from the cache controller: `addr`[31:0], `data`[127:0] (write line), `rw` (1 = write), `valid`.
- `mem_data_o`  out  `mem_data_type`  response to the cache controller: `data`[127:0] (refill line), `ready` (one-cycle completion pulse).
- `bus_req_o`  out  1  word-bus request; held high until acknowledged.
- `bus_we_o`  out  1  word-bus write enable.
- `bus_addr_o`  out  32  word-bus byte address; bits [1:0] are always 0.
- `bus_wdata_o`  out  32  word-bus write data.
- `bus_ack_i`  in  1  beat completion; read data is valid in the same cycle.
- `bus_rdata_i`  in  32  word-bus read data.
- `no_rd_line_o`  out  32  completed refill count.
- `no_wr_line_o`  out  32  completed write-back count.
- `no_stall_o`  out  32  count of cycles with `bus_req_o`=1 and `bus_ack_i`=0.

## Operation
- States: IDLE, BEAT, DONE.
- IDLE, `mem_req_i.valid`=1:
  - Latch `base = {addr[31:4],4'b0}`, `rw`, and `data` into the line buffer if `rw`=1.
  - Beat counter := 0; next state BEAT.
  - The request is sampled only here. Later changes to `mem_req_i` are ignored until the next IDLE.
- BEAT:
  - lane = (BASE_LANE + cnt) mod 4, 2-bit wrap.
  - Drive `bus_req_o`=1, `bus_we_o`=rw, `bus_addr_o`=base+4·lane, `bus_wdata_o`=line[32·lane+31:32·lane].
  - On `bus_ack_i`=1:
    - If read, line[lane] := `bus_rdata_i`.
    - If cnt=3, go to DONE; otherwise cnt+1.
  - On `bus_ack_i`=0: hold all bus outputs stable.
- DONE: `mem_data_o.ready`=1 for exactly this cycle; next state IDLE, unconditionally.
- `mem_data_o.data`:
  - Continuously reflects the line buffer.
  - After a refill it equals the assembled line until the next request is accepted.
  - After a write it equals the written line.
- Dropping `valid` mid-burst does not abort the burst. All four beats complete and `ready` still pulses.
- `valid` still high in the IDLE cycle after DONE starts a new transaction. This covers the controller's WRITE_BACK→ALLOCATE sequence with `valid` held.
- `bus_ack_i` is ignored in IDLE and DONE.
- Counters:
  - `no_rd_line_o` / `no_wr_line_o` increment in the DONE cycle.
  - `no_stall_o` increments per stalled BEAT cycle.
  - All three wrap modulo 2^32.

## Timing
- Reset: while `rst_i`=1, and immediately on its assertion, the following are forced low/zero:
  - state = IDLE, cnt = 0, line buffer = 0;
  - `bus_req_o`, `bus_we_o`, `bus_addr_o`, `bus_wdata_o`;
  - `mem_data_o.ready`, `mem_data_o.data`;
  - all counters.
- Reset mid-burst abandons the burst: `bus_req_o` drops asynchronously and no `ready` pulse is issued.
- Request accepted in cycle 0; `bus_req_o` rises in cycle 1.
- Zero-wait bus (ack every cycle): beats complete in cycles 1–4 and `ready` pulses in cycle 5. Minimum latency from valid to ready is 5 cycles.
- Each bus wait cycle adds one cycle of latency.
- Earliest next acceptance is cycle 6.

## Configuration
- `LINE_ADAPTER_STATS_EN`:
  - Defined: the three counters are implemented as specified.
  - Undefined: no counter registers exist, and `no_rd_line_o`, `no_wr_line_o`, `no_stall_o` are tied to 0.
  - Functional behaviour of the burst is identical either way.

## Test plan
- Refill, zero-wait, BASE_LANE=0:
  - Stimulus: addr 0x0000_1234, rw=0, bus returns 0x11, 0x22, 0x33, 0x44.
  - Required: bus addrs 0x1230, 0x1234, 0x1238, 0x123C; `ready` at cycle 5; data = 0x00000044_00000033_00000022_00000011.
- Write-back with 2 wait cycles per beat:
  - Stimulus: line 0xDDDD…_CCCC…_BBBB…_AAAA… to 0x8000_0010.
  - Required: 4 writes, lanes 0–3 in order; addr/data stable during waits; `ready` at cycle 13; `no_stall_o`=8.
- Back-to-back with `valid` held: write-back, then the same valid switched to rw=0.
  - Required: `ready` cycle 5; second burst `bus_req_o` at cycle 7; `ready` cycle 11.
- BASE_LANE=2 refill of 0x40:
  - Required: bus addr order 0x48, 0x4C, 0x40, 0x44; words land in the correct lanes.
- Reset mid-burst:
  - Stimulus: `rst_i` pulsed during beat 2.
  - Required: `bus_req_o`=0 immediately, no `ready` pulse, all counters 0; a new request afterwards completes normally.
- Stray `bus_ack_i` in IDLE, and `valid` dropped after acceptance:
  - Required: the stray ack has no effect; the burst still completes with 4 beats and one `ready`; with STATS_EN, `no_rd_line_o`=1.

Source files
------------

// File: rtl/line_mem_adapter.sv
// Cache-line to 32-bit word-bus adapter: one 128-bit request becomes a four-beat burst.
// Optional statistics counters are compiled in with `define LINE_ADAPTER_STATS_EN.

package line_mem_adapter_pkg;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

endpackage

module line_mem_adapter
    import line_mem_adapter_pkg::*;
#(
    parameter int unsigned BASE_LANE = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  mem_req_type  mem_req_i,
    output mem_data_type mem_data_o,
    output logic         bus_req_o,
    output logic         bus_we_o,
    output logic [31:0]  bus_addr_o,
    output logic [31:0]  bus_wdata_o,
    input  logic         bus_ack_i,
    input  logic [31:0]  bus_rdata_i,
    output logic [31:0]  no_rd_line_o,
    output logic [31:0]  no_wr_line_o,
    output logic [31:0]  no_stall_o
);

    typedef enum logic [1:0] {StIdle, StBeat, StDone} state_e;

    localparam logic [1:0] BaseLane = 2'(BASE_LANE);

    state_e       state_q, state_d;
    logic [1:0]   cnt_q;
    logic [27:0]  base_q;
    logic         rw_q;
    logic [127:0] line_q;
    logic [1:0]   lane;
    logic         beat_done;

    // Offset bits are dropped: bursts are always line aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_req_i.addr[3:0];

    assign lane      = BaseLane + cnt_q;
    assign beat_done = (state_q == StBeat) && bus_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (mem_req_i.valid) state_d = StBeat;
            StBeat: if (bus_ack_i && cnt_q == 2'd3) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        mem_data_o  = '{data: line_q, ready: 1'b0};
        unique case (state_q)
            StBeat: begin
                bus_req_o   = 1'b1;
                bus_we_o    = rw_q;
                bus_addr_o  = {base_q, lane, 2'b00};
                bus_wdata_o = line_q[{lane, 5'd0} +: 32];
            end
            StDone: mem_data_o.ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            base_q <= '0;
            rw_q   <= 1'b0;
            line_q <= '0;
        end else if (state_q == StIdle && mem_req_i.valid) begin
            cnt_q  <= '0;
            base_q <= mem_req_i.addr[31:4];
            rw_q   <= mem_req_i.rw;
            if (mem_req_i.rw) line_q <= mem_req_i.data;
        end else if (beat_done) begin
            // Counter wraps to 0 after the last beat, ready for the next burst.
            cnt_q <= cnt_q + 2'd1;
            if (!rw_q) line_q[{lane, 5'd0} +: 32] <= bus_rdata_i;
        end
    end

`ifdef LINE_ADAPTER_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state_q == StDone) begin
                if (rw_q) wr_cnt_q <= wr_cnt_q + 32'd1;
                else      rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (state_q == StBeat && !bus_ack_i) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign no_rd_line_o = rd_cnt_q;
    assign no_wr_line_o = wr_cnt_q;
    assign no_stall_o   = stall_cnt_q;
`else
    assign no_rd_line_o = '0;
    assign no_wr_line_o = '0;
    assign no_stall_o   = '0;
`endif

endmodule

// File: tb/tb_line_mem_adapter.sv
// Directed self-checking bench for line_mem_adapter (BASE_LANE 0 and 2 instances).
module tb_line_mem_adapter;
    import line_mem_adapter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    mem_req_type  req, req2;
    mem_data_type resp, resp2;
    logic         bus_req, bus_we, bus_ack, bus_req2, bus_we2, bus_ack2;
    logic [31:0]  bus_addr, bus_wdata, bus_rdata, bus_addr2, bus_wdata2, bus_rdata2;
    logic [31:0]  n_rd, n_wr, n_st, n_rd2, n_wr2, n_st2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0]  exp_rd, exp_wr, exp_stall;
    logic [127:0] line_w, line5;
    logic [31:0]  addr2_exp [4];

    line_mem_adapter #(.BASE_LANE(0)) dut (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req), .mem_data_o(resp),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
        .no_rd_line_o(n_rd), .no_wr_line_o(n_wr), .no_stall_o(n_st)
    );

    line_mem_adapter #(.BASE_LANE(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req2), .mem_data_o(resp2),
        .bus_req_o(bus_req2), .bus_we_o(bus_we2), .bus_addr_o(bus_addr2),
        .bus_wdata_o(bus_wdata2), .bus_ack_i(bus_ack2), .bus_rdata_i(bus_rdata2),
        .no_rd_line_o(n_rd2), .no_wr_line_o(n_wr2), .no_stall_o(n_st2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef LINE_ADAPTER_STATS_EN
        chk({tag, "_rd"}, 128'(n_rd), 128'(exp_rd));
        chk({tag, "_wr"}, 128'(n_wr), 128'(exp_wr));
        chk({tag, "_stall"}, 128'(n_st), 128'(exp_stall));
`else
        chk({tag, "_rd"}, 128'(n_rd), 128'd0);
        chk({tag, "_wr"}, 128'(n_wr), 128'd0);
        chk({tag, "_stall"}, 128'(n_st), 128'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        req = '0; req2 = '0;
        bus_ack = 1'b0; bus_rdata = '0; bus_ack2 = 1'b0; bus_rdata2 = '0;
        exp_rd = 0; exp_wr = 0; exp_stall = 0;
        #3;
        chk("rst_req", 128'(bus_req), 128'd0);
        chk("rst_ready", 128'(resp.ready), 128'd0);
        chk("rst_data", resp.data, 128'd0);
        chk("rst_addr", 128'(bus_addr), 128'd0);
        chk_stats("rst");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Refill, zero wait, BASE_LANE 0
        req.addr = 32'h0000_1234; req.rw = 1'b0; req.valid = 1'b1;
        tick();
        req.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_req", 128'(bus_req), 128'd1);
            chk("t1_we", 128'(bus_we), 128'd0);
            chk("t1_addr", 128'(bus_addr), 128'(32'h1230 + 32'(4 * i)));
            chk("t1_ready_early", 128'(resp.ready), 128'd0);
            bus_ack = 1'b1;
            bus_rdata = 32'(32'h11 * (i + 1));
            tick();
        end
        bus_ack = 1'b0;
        chk("t1_ready", 128'(resp.ready), 128'd1);
        chk("t1_req_done", 128'(bus_req), 128'd0);
        chk("t1_data", resp.data, 128'h00000044_00000033_00000022_00000011);
        tick();
        chk("t1_ready_once", 128'(resp.ready), 128'd0);
        chk("t1_data_hold", resp.data, 128'h00000044_00000033_00000022_00000011);
        exp_rd = 1;
        chk_stats("t1");

        // Write-back with two wait cycles per beat
        line_w = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        req.addr = 32'h8000_0010; req.data = line_w; req.rw = 1'b1; req.valid = 1'b1;
        tick();
        req.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 3; w++) begin
                chk("t2_req", 128'(bus_req), 128'd1);
                chk("t2_we", 128'(bus_we), 128'd1);
                chk("t2_addr", 128'(bus_addr), 128'(32'h8000_0010 + 32'(4 * i)));
                chk("t2_wdata", 128'(bus_wdata), 128'(line_w[32 * i +: 32]));
                chk("t2_ready_early", 128'(resp.ready), 128'd0);
                bus_ack = (w == 2);
                tick();
            end
        end
        bus_ack = 1'b0;
        chk("t2_ready13", 128'(resp.ready), 128'd1);
        chk("t2_data", resp.data, line_w);
        tick();
        exp_wr = 1; exp_stall = 8;
        chk_stats("t2");

        // Back-to-back with valid held: write-back then refill
        req.addr = 32'h0000_2000; req.data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        req.rw = 1'b1; req.valid = 1'b1;
        bus_ack = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t3_wr_req", 128'(bus_req), 128'd1);
            chk("t3_wr_addr", 128'(bus_addr), 128'(32'h2000 + 32'(4 * i)));
            tick();
        end
        chk("t3_ready5", 128'(resp.ready), 128'd1);
        req.rw = 1'b0;
        tick();
        chk("t3_idle6_req", 128'(bus_req), 128'd0);
        chk("t3_idle6_ready", 128'(resp.ready), 128'd0);
        tick();
        chk("t3_req7", 128'(bus_req), 128'd1);
        chk("t3_we7", 128'(bus_we), 128'd0);
        req.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_rd_addr", 128'(bus_addr), 128'(32'h2000 + 32'(4 * i)));
            bus_rdata = 32'hB000_0000 + 32'(i);
            tick();
        end
        chk("t3_ready11", 128'(resp.ready), 128'd1);
        chk("t3_data", resp.data, {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000});
        tick();
        bus_ack = 1'b0;
        chk("t3_ready_once", 128'(resp.ready), 128'd0);
        chk("t3_no_restart", 128'(bus_req), 128'd0);
        exp_wr = 2; exp_rd = 2;
        chk_stats("t3");

        // BASE_LANE 2 refill
        addr2_exp[0] = 32'h48; addr2_exp[1] = 32'h4C; addr2_exp[2] = 32'h40; addr2_exp[3] = 32'h44;
        req2.addr = 32'h40; req2.rw = 1'b0; req2.valid = 1'b1;
        tick();
        req2.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_req", 128'(bus_req2), 128'd1);
            chk("t4_addr", 128'(bus_addr2), 128'(addr2_exp[i]));
            bus_ack2 = 1'b1;
            bus_rdata2 = 32'hC0DE_0000 + 32'(i);
            tick();
        end
        bus_ack2 = 1'b0;
        chk("t4_ready", 128'(resp2.ready), 128'd1);
        chk("t4_data", resp2.data, {32'hC0DE_0001, 32'hC0DE_0000, 32'hC0DE_0003, 32'hC0DE_0002});
        tick();
`ifdef LINE_ADAPTER_STATS_EN
        chk("t4_rd2", 128'(n_rd2), 128'd1);
`else
        chk("t4_rd2", 128'(n_rd2), 128'd0);
`endif

        // Reset in the middle of a burst
        req.addr = 32'h0000_3000; req.rw = 1'b0; req.valid = 1'b1;
        tick();
        req.valid = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        tick();
        chk("t5_beat2_req", 128'(bus_req), 128'd1);
        chk("t5_beat2_addr", 128'(bus_addr), 128'h3004);
        bus_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_async_req", 128'(bus_req), 128'd0);
        chk("t5_async_addr", 128'(bus_addr), 128'd0);
        chk("t5_async_ready", 128'(resp.ready), 128'd0);
        chk("t5_async_data", resp.data, 128'd0);
        exp_rd = 0; exp_wr = 0; exp_stall = 0;
        chk_stats("t5_rst");
        tick();
        tick();
        rst = 1'b0;
        bus_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_no_ready", 128'(resp.ready), 128'd0);
            chk("t5_no_req", 128'(bus_req), 128'd0);
            tick();
        end
        line5 = 128'hFEED_0003_FEED_0002_FEED_0001_FEED_0000;
        req.addr = 32'h0000_4000; req.data = line5; req.rw = 1'b1; req.valid = 1'b1;
        tick();
        req.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_wdata", 128'(bus_wdata), 128'(line5[32 * i +: 32]));
            tick();
        end
        chk("t5_ready", 128'(resp.ready), 128'd1);
        tick();
        exp_wr = 1;
        chk_stats("t5_after");

        // Stray ack in IDLE, then valid dropped after acceptance
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            chk("t6_stray_req", 128'(bus_req), 128'd0);
            chk("t6_stray_ready", 128'(resp.ready), 128'd0);
            chk("t6_stray_data", resp.data, line5);
            tick();
        end
        chk_stats("t6_stray");
        bus_ack = 1'b0;
        req.addr = 32'h0000_5008; req.rw = 1'b0; req.valid = 1'b1;
        tick();
        req.valid = 1'b0; req.addr = 32'hFFFF_FFF0; req.rw = 1'b1;
        chk("t6_wait_addr", 128'(bus_addr), 128'h5000);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t6_addr", 128'(bus_addr), 128'(32'h5000 + 32'(4 * i)));
            chk("t6_we", 128'(bus_we), 128'd0);
            bus_ack = 1'b1;
            bus_rdata = 32'h61 + 32'(i);
            tick();
        end
        chk("t6_ready", 128'(resp.ready), 128'd1);
        chk("t6_data", resp.data, {32'h64, 32'h63, 32'h62, 32'h61});
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t6_single_ready", 128'(resp.ready), 128'd0);
            chk("t6_idle_req", 128'(bus_req), 128'd0);
            tick();
        end
        bus_ack = 1'b0;
        exp_rd = 1; exp_stall = 1;
        chk_stats("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
